alu_issue_stage: RTL

//  Decode/operand-fetch stage directly upstream of the ALU. Accepts 9-bit instructions over a valid/ready

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/reg_file.sv | 41 ++++
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the ALU issue stage: widths, opcodes, instruction fields,
// the issue FSM state type and the registered bundle presented to the ALU.
package isa_pkg;

  localparam int DW    = 8;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);
  localparam int IW    = 9;

  localparam logic [2:0] AND_OP  = 3'b000;
  localparam logic [2:0] ADD_OP  = 3'b001;
  localparam logic [2:0] XOR_OP  = 3'b010;
  localparam logic [2:0] HALT_OP = 3'b011;
  localparam logic [2:0] NOP0_OP = 3'b100;
  localparam logic [2:0] NOP1_OP = 3'b101;
  localparam logic [2:0] SUB_OP  = 3'b110;
  localparam logic [2:0] SHF_OP  = 3'b111;

  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int R1_MSB = 5;
  localparam int R1_LSB = 3;
  localparam int R2_MSB = 2;
  localparam int R2_LSB = 0;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} issue_state_t;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [DW-1:0] operand1;
    logic [DW-1:0] operand2;
    logic [2:0]    imm;
    logic [AW-1:0] rd;
  } alu_bundle_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    case (op)
      AND_OP, ADD_OP, XOR_OP, SUB_OP, SHF_OP: is_alu_op = 1'b1;
      HALT_OP, NOP0_OP, NOP1_OP:              is_alu_op = 1'b0;
      default:                                is_alu_op = 1'b0;
    endcase
  endfunction

  // Register-register forms read rs2; the rest carry the low field as an immediate.
  function automatic logic uses_rs2(input logic [2:0] op);
    uses_rs2 = (op == AND_OP) || (op == XOR_OP) || (op == SUB_OP);
  endfunction

  function automatic logic has_imm(input logic [2:0] op);
    has_imm = (op == ADD_OP) || (op == SHF_OP);
  endfunction

endpackage

// File: rtl/reg_file.sv
// NREGS x DW register file: two combinational read ports that bypass a same-cycle write,
// one synchronous write port, asynchronous reset to zero.
module reg_file
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] regs_reg [NREGS];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rdata [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (we) begin
      regs_reg[wa] <= wd;
    end
  end

  assign raddr[0] = ra1;
  assign raddr[1] = ra2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      assign rdata[gi] = (we && (wa == raddr[gi])) ? wd : regs_reg[raddr[gi]];
    end
  endgenerate

  assign rd1 = rdata[0];
  assign rd2 = rdata[1];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-fetch stage feeding the ALU, with RAW hazard stall and HALT drain.
// Optional ISSUE_STATS_EN adds issue_cnt/stall_cnt statistics outputs.
module alu_issue_stage
  import isa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    opcode,
  output logic [DW-1:0] operand1,
  output logic [DW-1:0] operand2,
  output logic [2:0]    imm,
  output logic [AW-1:0] rd,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          halted
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]   issue_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  issue_state_t  state_reg, state_next;
  alu_bundle_t   out_reg, bundle_next;
  logic          out_valid_reg;
  logic          pend_valid_reg;
  logic [AW-1:0] pend_rd_reg;

  logic [2:0]    dec_op;
  logic [AW-1:0] dec_rs1, dec_rs2;
  logic [DW-1:0] rs1_data, rs2_data;
  logic          src2, pend_clr, pend_hit, out_hit, stall, fire_in, out_hs;

  assign dec_op  = in_instr[OP_MSB:OP_LSB];
  assign dec_rs1 = in_instr[R1_MSB:R1_LSB];
  assign dec_rs2 = in_instr[R2_MSB:R2_LSB];
  assign src2    = uses_rs2(dec_op);

  reg_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (dec_rs1),
    .rd1 (rs1_data),
    .ra2 (dec_rs2),
    .rd2 (rs2_data),
    .we  (wb_en),
    .wa  (wb_addr),
    .wd  (wb_data)
  );

  // A writeback retiring the pending result this cycle is forwarded, so it no longer blocks.
  assign pend_clr = pend_valid_reg & wb_en & (wb_addr == pend_rd_reg);
  assign pend_hit = pend_valid_reg & ~pend_clr &
                    ((dec_rs1 == pend_rd_reg) | (src2 & (dec_rs2 == pend_rd_reg)));
  assign out_hit  = out_valid_reg &
                    ((dec_rs1 == out_reg.rd) | (src2 & (dec_rs2 == out_reg.rd)));
  assign stall    = pend_hit | out_hit;

  assign in_ready = (state_reg == RUN) & ~stall & (~out_valid_reg | out_ready);
  assign fire_in  = in_valid & in_ready;
  assign out_hs   = out_valid_reg & out_ready;

  always_comb begin
    bundle_next.opcode   = dec_op;
    bundle_next.operand1 = rs1_data;
    bundle_next.operand2 = src2 ? rs2_data : '0;
    bundle_next.imm      = has_imm(dec_op) ? dec_rs2 : 3'd0;
    bundle_next.rd       = dec_rs1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (fire_in && (dec_op == HALT_OP)) state_next = DRAIN;
      DRAIN:   if (!out_valid_reg && !pend_valid_reg) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // Output bundle: a new ALU op may replace the old one in the cycle it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else if (fire_in && is_alu_op(dec_op)) begin
      out_valid_reg <= 1'b1;
      out_reg       <= bundle_next;
    end else if (out_hs) begin
      out_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_reg <= 1'b0;
      pend_rd_reg    <= '0;
    end else if (out_hs) begin
      pend_valid_reg <= 1'b1;
      pend_rd_reg    <= out_reg.rd;
    end else if (pend_clr) begin
      pend_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign opcode    = out_reg.opcode;
  assign operand1  = out_reg.operand1;
  assign operand2  = out_reg.operand2;
  assign imm       = out_reg.imm;
  assign rd        = out_reg.rd;
  assign halted    = (state_reg == HALTED);

`ifdef ISSUE_STATS_EN
  logic [15:0] issue_cnt_reg, stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else if (state_reg != HALTED) begin
      if (out_hs)            issue_cnt_reg <= issue_cnt_reg + 16'd1;
      if (in_valid && stall) stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign issue_cnt = issue_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
